// File: rtl/rld_pkg.sv
// Shared definitions for the run-length detector: mode codes, state encoding
// and the polarity-enable helper used by both the y and hit paths.
package rld_pkg;

  localparam logic [1:0] MODE_ONES  = 2'b00;
  localparam logic [1:0] MODE_ZEROS = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN_ONE  = 2'b01,
    ST_RUN_ZERO = 2'b10
  } rld_state_e;

  function automatic logic mode_en(input logic [1:0] mode, input logic pol);
    case (mode)
      MODE_ONES:  mode_en = pol;
      MODE_ZEROS: mode_en = ~pol;
      MODE_BOTH:  mode_en = 1'b1;
      default:    mode_en = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/run_length_detector_sat_counter.sv
// Saturating up-counter with clear, load-to-one and increment controls.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load1,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clear)
      value_d = '0;
    else if (load1)
      value_d = WIDTH'(1);
    else if (inc && value_q != MAX_V)
      value_d = value_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/run_length_detector.sv
// Detects runs of identical bits on a qualified serial input, with separate
// thresholds per polarity, a one-shot hit per run and a saturating event count.
module run_length_detector
  import rld_pkg::*;
#(
  parameter int MAX_RUN = 15,
  parameter int RUN_W   = $clog2(MAX_RUN + 1),
  parameter int EVT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic [1:0]       mode,
  input  logic [RUN_W-1:0] thr_ones,
  input  logic [RUN_W-1:0] thr_zeros,
  output logic             y,
  output logic             hit,
  output logic             run_bit,
  output logic [RUN_W-1:0] run_len,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [RUN_W-1:0] MAX_L = RUN_W'(MAX_RUN);

  rld_state_e       state_q, state_d;
  logic             hit_q, hit_d;
  logic             done_q, done_d;   // this run has already produced its hit
  logic             new_run;
  logic [RUN_W-1:0] nxt_len;
  logic [RUN_W-1:0] nxt_thr;
  logic [RUN_W-1:0] cur_thr;

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    done_d  = done_q;
    new_run = (state_q == ST_IDLE) || (x != run_bit);
    nxt_len = new_run ? RUN_W'(1) : ((run_len == MAX_L) ? MAX_L : run_len + RUN_W'(1));
    nxt_thr = x ? thr_ones : thr_zeros;
    if (x_valid) begin
      state_d = x ? ST_RUN_ONE : ST_RUN_ZERO;
      // Hit only on the sample that lands exactly on the threshold, once per run.
      hit_d   = (new_run || !done_q) && mode_en(mode, x) &&
                (nxt_thr != '0) && (nxt_len == nxt_thr);
      done_d  = new_run ? hit_d : (done_q | hit_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
    end
  end

  sat_counter #(.WIDTH(RUN_W), .MAX(MAX_RUN)) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .load1 (x_valid & new_run),
    .inc   (x_valid & ~new_run),
    .value (run_len)
  );

  sat_counter #(.WIDTH(EVT_W), .MAX((1 << EVT_W) - 1)) u_evt_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .load1 (1'b0),
    .inc   (hit_d),
    .value (evt_cnt)
  );

  assign run_bit = (state_q == ST_RUN_ONE);
  assign hit     = hit_q;
  assign cur_thr = run_bit ? thr_ones : thr_zeros;
  assign y       = (state_q != ST_IDLE) && mode_en(mode, run_bit) &&
                   (cur_thr != '0) && (run_len >= cur_thr);

endmodule
